// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci generator / index decoder pair.
// Holds the FSM state type, the seed constants and an index-width helper.
package fib_pkg;

    typedef enum logic [1:0] {
        StIDLE,
        StCALC,
        StDONE
    } state_t;

    localparam int unsigned F0 = 0;
    localparam int unsigned F1 = 1;

    // Smallest index width w with 2^w > 1.45*bits + 2 (scaled by 100 to stay integer).
    function automatic int unsigned min_idx_w(input int unsigned bits);
        for (int unsigned w = 1; w < 31; w++) begin
            if ((longint'(100) << w) > longint'(145 * bits + 200)) begin
                return w;
            end
        end
        return 31;
    endfunction

endpackage

// File: rtl/fib_index_if.sv
// Request/result bundle of the Fibonacci index decoder: A/IEA in, N/EXACT/OE out.
interface fib_index_if #(
    parameter int BITS = 32,
    parameter int IDX  = 8
);
    logic [BITS-1:0] A;
    logic            IEA;
    logic [IDX-1:0]  N;
    logic            EXACT;
    logic            OE;

    modport master (output A, output IEA, input N, input EXACT, input OE);
    modport slave  (input A, input IEA, output N, output EXACT, output OE);
endinterface

// File: rtl/fib_step.sv
// One Fibonacci search step: advance (cur, nxt) while nxt still fits under target.
module fib_step
    import fib_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic [BITS-1:0] cur,
    input  logic [BITS:0]   nxt,
    input  logic [BITS-1:0] target,
    output logic [BITS-1:0] next_cur,
    output logic [BITS:0]   next_nxt,
    output logic            advance
);

    // The top bit of nxt marks a sum beyond BITS; it always compares greater than target.
    assign advance  = !nxt[BITS] && (nxt[BITS-1:0] <= target);
    assign next_cur = nxt[BITS-1:0];
    assign next_nxt = {1'b0, cur} + nxt;

endmodule

// File: rtl/fib_index.sv
// Fibonacci index decoder: returns the largest N with F(N) <= A plus an exact-match flag,
// searching one Fibonacci step per clock behind an IEA/OE level handshake.
module fib_index
    import fib_pkg::*;
#(
    parameter int BITS = 32,
    parameter int IDX  = 8
) (
    input  logic       CLK,
    input  logic       RST,
    fib_index_if.slave bus
);

    state_t          state, state_next;
    logic [BITS-1:0] target, target_next;
    logic [BITS-1:0] cur, cur_next;
    logic [BITS:0]   nxt, nxt_next;
    logic [IDX-1:0]  k, k_next;
    logic [IDX-1:0]  n, n_next;
    logic            exact, exact_next;
    logic            oe, oe_next;

    logic [BITS-1:0] step_cur;
    logic [BITS:0]   step_nxt;
    logic            advance;

    fib_step #(
        .BITS(BITS)
    ) u_step (
        .cur     (cur),
        .nxt     (nxt),
        .target  (target),
        .next_cur(step_cur),
        .next_nxt(step_nxt),
        .advance (advance)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= StIDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            target <= '0;
            cur    <= '0;
            nxt    <= '0;
            k      <= '0;
            n      <= '0;
            exact  <= 1'b0;
            oe     <= 1'b0;
        end else begin
            target <= target_next;
            cur    <= cur_next;
            nxt    <= nxt_next;
            k      <= k_next;
            n      <= n_next;
            exact  <= exact_next;
            oe     <= oe_next;
        end
    end

    always_comb begin
        state_next  = state;
        target_next = target;
        cur_next    = cur;
        nxt_next    = nxt;
        k_next      = k;
        n_next      = n;
        exact_next  = exact;
        oe_next     = oe;

        unique case (state)
            StIDLE: begin
                if (bus.IEA) begin
                    target_next = bus.A;
                    if (bus.A == BITS'(F0)) begin
                        n_next     = '0;
                        exact_next = 1'b1;
                        oe_next    = 1'b1;
                        state_next = StDONE;
                    end else begin
                        // Seed with F(1)=1 in cur and F(2)=1 in nxt so A=1 resolves to N=2.
                        cur_next   = BITS'(F1);
                        nxt_next   = (BITS + 1)'(F1);
                        k_next     = IDX'(1);
                        state_next = StCALC;
                    end
                end
            end

            StCALC: begin
                if (advance) begin
                    cur_next = step_cur;
                    nxt_next = step_nxt;
                    k_next   = k + IDX'(1);
                end else begin
                    n_next     = k;
                    exact_next = (cur == target);
                    oe_next    = 1'b1;
                    state_next = StDONE;
                end
            end

            StDONE: begin
                if (oe && !bus.IEA) begin
                    oe_next    = 1'b0;
                    state_next = StIDLE;
                end
            end

            default: begin
                state_next = StIDLE;
            end
        endcase
    end

    assign bus.N     = n;
    assign bus.EXACT = exact;
    assign bus.OE    = oe;

endmodule

// File: tb/tb_fib_index.sv
// Bench for fib_index: directed corner requests plus random values, each compared
// against a Fibonacci-table reference for index, exact flag, latency and handshake.
module tb_fib_index;
    import fib_pkg::*;

    localparam int BITS = 32;
    localparam int IDX  = 8;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    longint fibs [0:48];

    fib_index_if #(.BITS(BITS), .IDX(IDX)) bus ();

    fib_index #(
        .BITS(BITS),
        .IDX (IDX)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Largest n with F(n) <= a, found by scanning the Fibonacci table.
    task automatic ref_model(input logic [31:0] a, output int n, output bit ex);
        n = 0;
        for (int i = 0; i <= 48; i++) begin
            if (fibs[i] <= longint'(a)) n = i;
        end
        ex = (fibs[n] == longint'(a));
    endtask

    // Issue one request, check result and latency, optionally disturb A/IEA mid-search,
    // hold IEA for `hold` cycles after OE, then release and check the return to idle.
    task automatic run_req(input logic [31:0] a, input bit perturb, input int hold);
        int n_exp;
        bit ex_exp;
        int edges;
        bit got;
        ref_model(a, n_exp, ex_exp);
        @(negedge clk);
        bus.A   = a;
        bus.IEA = 1'b1;
        edges   = 0;
        got     = 1'b0;
        while (!got && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.OE) begin
                got = 1'b1;
            end else if (perturb && edges == 1) begin
                bus.A   = $urandom;
                bus.IEA = 1'b0;
            end else if (perturb && edges == 2) begin
                bus.IEA = 1'b1;
            end
        end
        check("oe_seen", 64'(got), 64'(1));
        if (!got) begin
            bus.IEA = 1'b0;
            repeat (2) @(posedge clk);
            return;
        end
        // Edges counted include the accepting edge.
        check("latency", 64'(edges), 64'((a == 0) ? 1 : n_exp + 1));
        check("n", 64'(bus.N), 64'(n_exp));
        check("exact", 64'(bus.EXACT), 64'(ex_exp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_oe", 64'(bus.OE), 64'(1));
            check("hold_n", 64'(bus.N), 64'(n_exp));
        end
        bus.IEA = 1'b0;
        bus.A   = $urandom;
        @(posedge clk);
        #1;
        check("drop_oe", 64'(bus.OE), 64'(0));
        check("drop_n", 64'(bus.N), 64'(n_exp));
        check("drop_exact", 64'(bus.EXACT), 64'(ex_exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int idx;
        vectors     = 0;
        miscompares = 0;
        fibs[0] = 0;
        fibs[1] = 1;
        for (int i = 2; i <= 48; i++) fibs[i] = fibs[i-1] + fibs[i-2];

        bus.A   = '0;
        bus.IEA = 1'b0;
        rst     = 1'b1;
        #1;
        check("rst_oe", 64'(bus.OE), 64'(0));
        check("rst_n", 64'(bus.N), 64'(0));
        check("rst_exact", 64'(bus.EXACT), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_req(32'd0, 1'b0, 0);
        run_req(32'd1, 1'b0, 0);
        run_req(32'd5, 1'b0, 0);
        run_req(32'd4, 1'b0, 0);
        run_req(32'hFFFF_FFFF, 1'b0, 0);
        run_req(32'd2971215073, 1'b0, 0);
        run_req(32'd2971215072, 1'b0, 0);
        run_req(32'd20, 1'b1, 10);

        // Asynchronous reset in the middle of a search.
        @(negedge clk);
        bus.A   = 32'd1000;
        bus.IEA = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_oe", 64'(bus.OE), 64'(0));
        check("arst_n", 64'(bus.N), 64'(0));
        check("arst_exact", 64'(bus.EXACT), 64'(0));
        bus.IEA = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("arst_idle_oe", 64'(bus.OE), 64'(0));

        run_req(32'd144, 1'b0, 0);
        run_req(32'd8, 1'b0, 0);
        run_req(32'd13, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            idx = int'($urandom_range(2, 47));
            case ($urandom_range(0, 3))
                0: a = $urandom;
                1: a = 32'($urandom_range(0, 300));
                2: a = 32'(fibs[idx]);
                default: a = ($urandom_range(0, 1) == 1) ? 32'(fibs[idx] + 1) : 32'(fibs[idx] - 1);
            endcase
            run_req(a, ($urandom_range(0, 3) == 0) && (a > 32'd5), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
